// File: rtl/mem_port_arbiter.sv
// Shares one req/ack memory port between instruction fetch and the MEM stage.
// MEM has fixed priority; each access ends with a one-cycle DONE that pulses completion.
module mem_port_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,

  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  output logic [DW-1:0] if_data_o,
  output logic          if_valid_o,
  output logic          if_stall_o,

  input  logic          mem_read_i,
  input  logic          mem_write_i,
  input  logic [AW-1:0] mem_addr_i,
  input  logic [DW-1:0] mem_wdata_i,
  output logic [DW-1:0] mem_rdata_o,
  output logic          mem_done_o,
  output logic          mem_stall_o,

  output logic          m_req_o,
  output logic          m_we_o,
  output logic [AW-1:0] m_addr_o,
  output logic [DW-1:0] m_wdata_o,
  input  logic          m_ack_i,
  input  logic [DW-1:0] m_rdata_i,

  output logic          busy_o,
  output logic          err_o
);

  // Watchdog counts 0..TIMEOUT-1; the abort fires in the cycle it holds TIMEOUT-1.
  localparam int unsigned     CntW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StIfAcc,
    StMemAcc,
    StDone
  } state_e;

  state_e          state_q;
  logic            req_q;
  logic            we_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [DW-1:0]   if_data_q;
  logic [DW-1:0]   mem_rdata_q;
  logic            if_valid_q;
  logic            mem_done_q;
  logic            err_q;
  logic [CntW-1:0] wdog_q;

  logic mem_any;
  logic timeout_hit;

  assign mem_any     = mem_read_i | mem_write_i;
  assign timeout_hit = (TIMEOUT != 0) && (wdog_q == CntLast);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= StIdle;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
      if_valid_q  <= 1'b0;
      mem_done_q  <= 1'b0;
      err_q       <= 1'b0;
      wdog_q      <= '0;
    end else begin
      if_valid_q <= 1'b0;
      mem_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          wdog_q <= '0;
          if (start_i && mem_any) begin
            state_q <= StMemAcc;
            req_q   <= 1'b1;
            we_q    <= mem_write_i;
            addr_q  <= mem_addr_i;
            wdata_q <= mem_wdata_i;
          end else if (start_i && if_req_i) begin
            state_q <= StIfAcc;
            req_q   <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= if_addr_i;
            wdata_q <= '0;
          end
        end

        StIfAcc: begin
          if (m_ack_i) begin
            state_q    <= StDone;
            req_q      <= 1'b0;
            if_data_q  <= m_rdata_i;
            if_valid_q <= 1'b1;
          end else if (timeout_hit) begin
            state_q    <= StDone;
            req_q      <= 1'b0;
            err_q      <= 1'b1;
            if_data_q  <= '0;
            if_valid_q <= 1'b1;
          end else begin
            wdog_q <= wdog_q + CntW'(1);
          end
        end

        StMemAcc: begin
          if (m_ack_i) begin
            state_q    <= StDone;
            req_q      <= 1'b0;
            mem_done_q <= 1'b1;
            if (!we_q) begin
              mem_rdata_q <= m_rdata_i;
            end
          end else if (timeout_hit) begin
            // Aborted accesses still complete so the pipeline never deadlocks.
            state_q     <= StDone;
            req_q       <= 1'b0;
            err_q       <= 1'b1;
            mem_rdata_q <= '0;
            mem_done_q  <= 1'b1;
          end else begin
            wdog_q <= wdog_q + CntW'(1);
          end
        end

        StDone: begin
          state_q <= StIdle;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign m_req_o     = req_q;
  assign m_we_o      = we_q;
  assign m_addr_o    = addr_q;
  assign m_wdata_o   = wdata_q;
  assign if_data_o   = if_data_q;
  assign if_valid_o  = if_valid_q;
  assign mem_rdata_o = mem_rdata_q;
  assign mem_done_o  = mem_done_q;
  assign err_o       = err_q;
  assign busy_o      = (state_q != StIdle);

  // Stalls release in the completion cycle so the pipeline advances exactly once.
  assign mem_stall_o = rst_i & mem_any & ~mem_done_q;
  assign if_stall_o  = rst_i & if_req_i & ~if_valid_q;

  assert property (@(posedge clk_i) disable iff (!rst_i) !(if_valid_o && mem_done_o));
  assert property (@(posedge clk_i) disable iff (!rst_i) m_req_o |-> busy_o);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level model of grant priority, latency, timeout and data capture.
module tb_mem_port_arbiter;

  localparam int unsigned TO = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_data_o;
  logic        if_valid_o;
  logic        if_stall_o;
  logic        mem_read_i;
  logic        mem_write_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic [31:0] mem_rdata_o;
  logic        mem_done_o;
  logic        mem_stall_o;
  logic        m_req_o;
  logic        m_we_o;
  logic [31:0] m_addr_o;
  logic [31:0] m_wdata_o;
  logic        m_ack_i;
  logic [31:0] m_rdata_i;
  logic        busy_o;
  logic        err_o;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_if_data;
  logic [31:0] exp_mem_rdata;
  logic        exp_err;

  mem_port_arbiter #(
    .AW     (32),
    .DW     (32),
    .TIMEOUT(TO)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .if_req_i   (if_req_i),
    .if_addr_i  (if_addr_i),
    .if_data_o  (if_data_o),
    .if_valid_o (if_valid_o),
    .if_stall_o (if_stall_o),
    .mem_read_i (mem_read_i),
    .mem_write_i(mem_write_i),
    .mem_addr_i (mem_addr_i),
    .mem_wdata_i(mem_wdata_i),
    .mem_rdata_o(mem_rdata_o),
    .mem_done_o (mem_done_o),
    .mem_stall_o(mem_stall_o),
    .m_req_o    (m_req_o),
    .m_we_o     (m_we_o),
    .m_addr_o   (m_addr_o),
    .m_wdata_o  (m_wdata_o),
    .m_ack_i    (m_ack_i),
    .m_rdata_i  (m_rdata_i),
    .busy_o     (busy_o),
    .err_o      (err_o)
  );

  always #5 clk_i = ~clk_i;

  // Serves one access. Entered just after a posedge in an idle cycle with the request
  // already driven; returns just after the posedge following DONE, with the served
  // request withdrawn (the pipeline advanced).
  task automatic serve(input bit is_mem, input int dly, input logic [31:0] rd,
                       input bit drop_start, input string tag);
    bit          abort;
    bit          exp_we;
    bit          exp_ms;
    bit          exp_is;
    int          req_cycles;
    logic [31:0] exp_addr;
    logic [31:0] exp_wd;
    exp_we     = is_mem && mem_write_i;
    exp_addr   = is_mem ? mem_addr_i : if_addr_i;
    exp_wd     = mem_wdata_i;
    abort      = (dly >= int'(TO));
    req_cycles = abort ? int'(TO) : dly + 1;

    @(negedge clk_i);
    checks++;
    if (m_req_o !== 1'b0 || busy_o !== 1'b0 || if_valid_o !== 1'b0 || mem_done_o !== 1'b0 ||
        err_o !== exp_err) begin
      failures++;
      $display("FAIL %s idle: req=%b busy=%b valid=%b done=%b err=%b, want 0 0 0 0 %b",
               tag, m_req_o, busy_o, if_valid_o, mem_done_o, err_o, exp_err);
    end
    checks++;
    if (mem_stall_o !== (mem_read_i | mem_write_i) || if_stall_o !== if_req_i) begin
      failures++;
      $display("FAIL %s idle stall: mem_stall=%b if_stall=%b, want %b %b", tag, mem_stall_o,
               if_stall_o, mem_read_i | mem_write_i, if_req_i);
    end

    for (int j = 0; j < req_cycles; j++) begin
      @(posedge clk_i); #1;
      if (drop_start && j == 0) start_i = 1'b0;
      m_ack_i   = (j == dly);
      m_rdata_i = (j == dly) ? rd : $urandom;
      @(negedge clk_i);
      checks++;
      if (m_req_o !== 1'b1 || m_addr_o !== exp_addr || m_we_o !== exp_we || busy_o !== 1'b1) begin
        failures++;
        $display("FAIL %s acc cycle %0d: req=%b addr=%h we=%b busy=%b, want 1 %h %b 1",
                 tag, j, m_req_o, m_addr_o, m_we_o, busy_o, exp_addr, exp_we);
      end
      if (exp_we) begin
        checks++;
        if (m_wdata_o !== exp_wd) begin
          failures++;
          $display("FAIL %s wdata: got %h want %h", tag, m_wdata_o, exp_wd);
        end
      end
      checks++;
      if (mem_stall_o !== (mem_read_i | mem_write_i) || if_stall_o !== if_req_i) begin
        failures++;
        $display("FAIL %s acc stall: mem_stall=%b if_stall=%b, want %b %b", tag, mem_stall_o,
                 if_stall_o, mem_read_i | mem_write_i, if_req_i);
      end
    end

    // DONE cycle; a stray ack here must be ignored.
    @(posedge clk_i); #1;
    m_ack_i   = 1'($urandom_range(0, 1));
    m_rdata_i = $urandom;
    if (abort) begin
      exp_err = 1'b1;
      if (is_mem) exp_mem_rdata = '0;
      else        exp_if_data   = '0;
    end else if (is_mem) begin
      if (!exp_we) exp_mem_rdata = rd;
    end else begin
      exp_if_data = rd;
    end
    exp_ms = is_mem ? 1'b0 : (mem_read_i | mem_write_i);
    exp_is = is_mem ? if_req_i : 1'b0;
    @(negedge clk_i);
    checks++;
    if (m_req_o !== 1'b0 || busy_o !== 1'b1 || if_valid_o !== !is_mem ||
        mem_done_o !== is_mem) begin
      failures++;
      $display("FAIL %s done: req=%b busy=%b valid=%b done=%b, want 0 1 %b %b",
               tag, m_req_o, busy_o, if_valid_o, mem_done_o, !is_mem, is_mem);
    end
    checks++;
    if (if_data_o !== exp_if_data || mem_rdata_o !== exp_mem_rdata || err_o !== exp_err) begin
      failures++;
      $display("FAIL %s data: if_data=%h mem_rdata=%h err=%b, want %h %h %b", tag, if_data_o,
               mem_rdata_o, err_o, exp_if_data, exp_mem_rdata, exp_err);
    end
    checks++;
    if (mem_stall_o !== exp_ms || if_stall_o !== exp_is) begin
      failures++;
      $display("FAIL %s done stall: mem_stall=%b if_stall=%b, want %b %b", tag, mem_stall_o,
               if_stall_o, exp_ms, exp_is);
    end

    @(posedge clk_i); #1;
    m_ack_i = 1'b0;
    if (is_mem) begin
      mem_read_i  = 1'b0;
      mem_write_i = 1'b0;
    end else begin
      if_req_i = 1'b0;
    end
  endtask

  task automatic check_quiet(input string tag);
    @(negedge clk_i);
    checks++;
    if (m_req_o !== 1'b0 || busy_o !== 1'b0 || if_valid_o !== 1'b0 || mem_done_o !== 1'b0 ||
        if_data_o !== exp_if_data || mem_rdata_o !== exp_mem_rdata || err_o !== exp_err) begin
      failures++;
      $display("FAIL %s quiet: req=%b busy=%b valid=%b done=%b if_data=%h mem_rdata=%h err=%b",
               tag, m_req_o, busy_o, if_valid_o, mem_done_o, if_data_o, mem_rdata_o, err_o);
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b0; start_i = 1'b0; if_req_i = 1'b0; if_addr_i = '0;
    mem_read_i = 1'b0; mem_write_i = 1'b0; mem_addr_i = '0; mem_wdata_i = '0;
    m_ack_i = 1'b0; m_rdata_i = '0;
    exp_if_data = '0; exp_mem_rdata = '0; exp_err = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    checks++;
    if ({m_req_o, m_we_o, m_addr_o, m_wdata_o, if_data_o, if_valid_o, if_stall_o, mem_rdata_o,
         mem_done_o, mem_stall_o, busy_o, err_o} !== '0) begin
      failures++;
      $display("FAIL reset: req=%b we=%b addr=%h busy=%b err=%b valid=%b done=%b, want all 0",
               m_req_o, m_we_o, m_addr_o, busy_o, err_o, if_valid_o, mem_done_o);
    end
    rst_i = 1'b1;
    start_i = 1'b1;
    @(posedge clk_i); #1;
    check_quiet("after_reset");
  endtask

  task automatic test_if_only();
    if_req_i = 1'b1; if_addr_i = 32'h100;
    serve(1'b0, 3, 32'hDEADBEEF, 1'b0, "if_only");
  endtask

  task automatic test_contention();
    if_req_i = 1'b1; if_addr_i = 32'h300;
    mem_write_i = 1'b1; mem_addr_i = 32'h200; mem_wdata_i = 32'h1234;
    serve(1'b1, 1, 32'hAAAA5555, 1'b0, "contention_mem");
    serve(1'b0, 0, 32'h0BADF00D, 1'b0, "contention_if");
  endtask

  task automatic test_held();
    mem_read_i = 1'b1; mem_addr_i = 32'h440;
    serve(1'b1, 2, 32'hC0FFEE01, 1'b0, "held");
    check_quiet("held_no_regrant");
  endtask

  task automatic test_ack_ignored();
    for (int i = 0; i < 3; i++) begin
      m_ack_i = 1'b1;
      m_rdata_i = $urandom;
      check_quiet("ack_idle");
    end
    m_ack_i = 1'b0;
  endtask

  task automatic test_start_low();
    start_i = 1'b0;
    if_req_i = 1'b1; if_addr_i = 32'h500;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      checks++;
      if (m_req_o !== 1'b0 || busy_o !== 1'b0 || if_stall_o !== 1'b1) begin
        failures++;
        $display("FAIL start_low: req=%b busy=%b if_stall=%b, want 0 0 1",
                 m_req_o, busy_o, if_stall_o);
      end
      @(posedge clk_i); #1;
    end
    start_i = 1'b1;
    serve(1'b0, 1, 32'h13572468, 1'b0, "start_raise");
    mem_read_i = 1'b1; mem_addr_i = 32'h600;
    serve(1'b1, 2, 32'h24681357, 1'b1, "start_drop_mid");
    start_i = 1'b1;
  endtask

  task automatic test_random();
    bit ifr;
    bit mr;
    bit mw;
    for (int n = 0; n < 30; n++) begin
      ifr = 1'($urandom_range(0, 1));
      mr  = 1'($urandom_range(0, 1));
      mw  = 1'($urandom_range(0, 1));
      if (!(ifr | mr | mw)) ifr = 1'b1;
      if_req_i = ifr; if_addr_i = $urandom;
      mem_read_i = mr; mem_write_i = mw; mem_addr_i = $urandom; mem_wdata_i = $urandom;
      if (mr | mw) serve(1'b1, int'($urandom_range(0, 6)), $urandom, 1'b0, "rand_mem");
      if (ifr)     serve(1'b0, int'($urandom_range(0, 6)), $urandom, 1'b0, "rand_if");
    end
  endtask

  task automatic test_timeout();
    mem_read_i = 1'b1; mem_addr_i = 32'h700;
    serve(1'b1, 20, 32'hFFFFFFFF, 1'b0, "timeout");
    if_req_i = 1'b1; if_addr_i = 32'h704;
    serve(1'b0, 0, 32'h600DD00D, 1'b0, "after_timeout");
  endtask

  task automatic test_reset_mid();
    mem_read_i = 1'b1; mem_addr_i = 32'h800;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    checks++;
    if (m_req_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid setup: req=%b want 1", m_req_o);
    end
    @(posedge clk_i); #2;
    rst_i = 1'b0;
    exp_if_data = '0; exp_mem_rdata = '0; exp_err = 1'b0;
    #1;
    checks++;
    if (m_req_o !== 1'b0 || busy_o !== 1'b0 || err_o !== 1'b0 || mem_rdata_o !== '0) begin
      failures++;
      $display("FAIL reset_mid async: req=%b busy=%b err=%b mem_rdata=%h, want 0 0 0 0",
               m_req_o, busy_o, err_o, mem_rdata_o);
    end
    mem_read_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    check_quiet("reset_mid_release");
    if_req_i = 1'b1; if_addr_i = 32'h900;
    serve(1'b0, 2, 32'h87654321, 1'b0, "reset_mid_new");
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_if_only();
    test_contention();
    test_held();
    test_ack_ignored();
    test_start_low();
    test_random();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
